game_tick_scheduler: RTL and testbench
======================================

GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 Parameter PRESCALE, default 1_000_000, SHALL set the clk cycles per base tick (10 ms at 100 MHz); legal range 2..2^32-1.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 pause  input  1  SHALL, while high, freeze the prescaler and all channel counters.
REQ-005 cfg_we  input  1  SHALL be the one-cycle configuration write strobe.
REQ-006 cfg_ch  input  2  SHALL select the channel (0..3) that the write targets.
REQ-007 cfg_period  input  8  SHALL give the channel period in base ticks; 0 means the channel is disabled.
REQ-008 evt_ready  input  1  SHALL be high when the consumer accepts the presented event.
REQ-009 overrun_clr  input  1  SHALL, when high, clear all overrun flags.
REQ-010 evt_valid  output  1  SHALL be high when an event is presented.
REQ-011 evt_id  output  2  SHALL give the channel of the presented event.
REQ-012 base_tick  output  1  SHALL pulse for one cycle per prescaler wrap.
REQ-013 overrun  output  4  SHALL hold sticky per-channel lost-event flags.

Function
REQ-014 Prescaler:
- 32-bit count, 0..PRESCALE-1, advancing while pause=0.
- base_tick SHALL be asserted, combinationally, in the cycle where count==PRESCALE-1 and pause=0; the count then wraps to 0.
REQ-015 Channel counters:
- Four 8-bit counters, one per channel.
- On base_tick, each channel with period p!=0 SHALL expire if cnt==p-1 (cnt<=0); otherwise cnt<=cnt+1.
- A channel with p==0 SHALL never expire and SHALL hold cnt at 0.
REQ-016 Expiry SHALL set pending[i] at the clock edge that ends the base_tick cycle.
REQ-017 Overrun: an expiry while pending[i]=1 SHALL set overrun[i]=1.
- Exception: if pending[i] is cleared by a handshake on the same edge, pending[i] SHALL stay 1 and no overrun is raised.
REQ-018 Overrun clear: overrun_clr SHALL clear all overrun bits on the next edge. A simultaneous new overrun SHALL win, leaving that bit at 1.
REQ-019 Presenting an event: when evt_valid=0 and any pending bit is set, the next edge SHALL assert evt_valid and load evt_id with the round-robin winner.
- Search SHALL start at last_grant+1 (mod 4).
- last_grant SHALL reset to 3, so channel 0 has first priority.
REQ-020 Presenter FSM SHALL have two states:
- IDLE -> PRESENT when any pending bit is set.
- PRESENT -> IDLE on handshake (evt_valid & evt_ready).
REQ-021 In PRESENT, evt_id SHALL remain stable until handshake.
- On the handshake edge: pending[evt_id]<=0 (subject to REQ-017), last_grant<=evt_id, evt_valid<=0.
- Maximum throughput SHALL be one event per 2 cycles.
REQ-022 Latency from the base_tick cycle to evt_valid high SHALL be 2 cycles when IDLE and no other pending event wins.
REQ-023 Config write: cfg_we SHALL, on the next edge, load period[cfg_ch] and zero cnt[cfg_ch].
- It SHALL also clear pending[cfg_ch], unless that channel is currently presented, in which case pending and the handshake are unaffected.
REQ-024 A cfg_we to channel i in a base_tick cycle SHALL override that channel's count/expiry: no expiry, cnt=0.
REQ-025 pause SHALL NOT affect pending, the presenter FSM, or the handshake. Events already pending SHALL still be delivered while paused.

Reset
REQ-026 rst_n low SHALL immediately force:
- prescaler=0, all cnt=0, all period=0, pending=0, overrun=0;
- evt_valid=0, evt_id=0, last_grant=3, FSM=IDLE;
- base_tick=0.
REQ-027 Reset asserted mid-handshake SHALL discard the presented event and all pending events. No event SHALL be generated until a channel is reconfigured.

Verification (bench PRESCALE=4)
REQ-028 Scenario 1, steady single channel:
- Stimulus: cfg ch0 period 3, evt_ready=1.
- Response: base_tick every 4 cycles; evt_valid one-cycle pulses with evt_id=0 every 12 cycles, each 2 cycles after every 3rd base_tick.
REQ-029 Scenario 2, round robin:
- Stimulus: ch0 and ch2 period 1, evt_ready=1.
- Response: grants in order 0,2 after each base_tick; no overrun.
REQ-030 Scenario 3, overrun:
- Stimulus: ch1 period 1, evt_ready=0 for 3 base ticks.
- Response: evt_valid=1 and evt_id=1 held stable; overrun=4'b0010.
- Then overrun_clr pulse -> overrun=0. Then evt_ready=1 -> single handshake, pending[1] cleared.
REQ-031 Scenario 4, pause:
- Stimulus: ch3 period 2; pause high for 20 cycles starting 1 cycle after the first base_tick.
- Response: no base_tick and cnt3 frozen at 1 during pause; first evt_id=3 event 5 cycles after pause release.
REQ-032 Scenario 5, config collisions:
- cfg_we to presented channel 0 -> evt_valid and evt_id held until handshake.
- cfg_we to ch2 in its expiry cycle -> no ch2 event.
REQ-033 Scenario 6, reset mid-operation: rst_n pulsed low while evt_valid=1 -> all outputs 0 asynchronously; no event for 50 cycles after release.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: a prescaled base tick drives four periodic channels.
// Channel expiries are queued as pending events and presented one at a time
// over a valid/ready handshake, granted round-robin.
module game_tick_scheduler #(
    parameter int unsigned PRESCALE = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause,
    input  logic       cfg_we,
    input  logic [1:0] cfg_ch,
    input  logic [7:0] cfg_period,
    input  logic       evt_ready,
    input  logic       overrun_clr,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    output logic       base_tick,
    output logic [3:0] overrun
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PRE_W  = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [PRE_W-1:0]  presc_q;
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] ov_set;
    logic [NUM_CH-1:0] overrun_d;
    logic [CH_W-1:0]   last_q;
    logic [CH_W-1:0]   last_d;
    logic [CH_W-1:0]   rr_idx;
    logic [CH_W-1:0]   rr_winner;
    logic              rr_found;
    logic              handshake;
    state_t            state_q;
    state_t            state_d;
    logic              valid_d;
    logic [CH_W-1:0]   id_d;

    // Base tick fires in the last prescaler cycle unless paused.
    always_comb begin
        base_tick = (presc_q == PRE_W'(PRESCALE - 1)) && !pause;
    end

    // Prescaler count, frozen while paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (base_tick) begin
            presc_q <= '0;
        end else if (!pause) begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Channel period/count next state; a config write overrides any expiry.
    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                period_d[i] = cfg_period;
                cnt_d[i]    = '0;
            end else if (base_tick && (period_q[i] != '0)) begin
                if (cnt_q[i] == period_q[i] - CNT_W'(1)) begin
                    expire[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Channel period and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign handshake = evt_valid && evt_ready;

    // Pending/overrun next state; an expiry beats a same-edge clear.
    always_comb begin
        ov_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pending_d[i] = pending_q[i];
            if (handshake && (evt_id == CH_W'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (cfg_we && (cfg_ch == CH_W'(i)) && !(evt_valid && (evt_id == CH_W'(i)))) begin
                pending_d[i] = 1'b0;
            end
            if (expire[i]) begin
                pending_d[i] = 1'b1;
                ov_set[i]    = pending_q[i] && !(handshake && (evt_id == CH_W'(i)));
            end
        end
        overrun_d = (overrun_clr ? '0 : overrun) | ov_set;
    end

    // Round-robin search starting after the last granted channel.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_q;
        rr_idx    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            rr_idx = last_q + CH_W'(k);
            if (!rr_found && pending_q[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    // Presenter next state: load a winner when idle, retire on handshake.
    always_comb begin
        state_d = state_q;
        valid_d = evt_valid;
        id_d    = evt_id;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d = ST_PRESENT;
                    valid_d = 1'b1;
                    id_d    = rr_winner;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    last_d  = evt_id;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Presenter, pending and overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            last_q    <= CH_W'(NUM_CH - 1);
            pending_q <= '0;
            overrun   <= '0;
        end else begin
            state_q   <= state_d;
            evt_valid <= valid_d;
            evt_id    <= id_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Randomized scoreboard bench for game_tick_scheduler with a behavioural model.
module tb_game_tick_scheduler;

    localparam int unsigned PRESCALE = 4;

    logic       clk;
    logic       rst_n;
    logic       pause;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic       evt_ready;
    logic       overrun_clr;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       base_tick;
    logic [3:0] overrun;

    game_tick_scheduler #(.PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pause      (pause),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .evt_ready  (evt_ready),
        .overrun_clr(overrun_clr),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .base_tick  (base_tick),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time-based rules, not register mirrors.
    int unsigned run_cnt;
    int          per   [4];
    int          ticks [4];
    bit          pend  [4];
    bit          newp  [4];
    bit          ex    [4];
    bit          ovr   [4];
    bit          m_valid;
    int          m_id;
    int          m_last;
    bit          m_tick;
    bit          m_hs;
    int          exp_q [$];

    function automatic int ovr_word();
        int w = 0;
        for (int i = 0; i < 4; i++) if (ovr[i]) w += (1 << i);
        return w;
    endfunction

    // Model: compare this cycle's outputs, then advance to the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_cnt = 0;
            m_valid = 0;
            m_id    = 0;
            m_last  = 3;
            for (int i = 0; i < 4; i++) begin
                per[i] = 0; ticks[i] = 0; pend[i] = 0; ovr[i] = 0;
            end
            exp_q.delete();
            chk("reset_valid", int'(evt_valid), 0);
            chk("reset_overrun", int'(overrun), 0);
            chk("reset_tick", int'(base_tick), 0);
        end else begin
            m_tick = !pause && ((run_cnt % PRESCALE) == PRESCALE - 1);
            chk("base_tick", int'(base_tick), int'(m_tick));
            chk("evt_valid", int'(evt_valid), int'(m_valid));
            chk("overrun", int'(overrun), ovr_word());
            if (m_valid) chk("evt_id_stable", int'(evt_id), m_id);
            if (!pause) run_cnt++;
            m_hs = m_valid && evt_ready;
            for (int i = 0; i < 4; i++) begin
                ex[i]   = 0;
                newp[i] = pend[i];
                if (m_hs && m_id == i) newp[i] = 0;
                if (cfg_we && int'(cfg_ch) == i) begin
                    per[i]   = int'(cfg_period);
                    ticks[i] = 0;
                    if (!(m_valid && m_id == i)) newp[i] = 0;
                end else if (m_tick && per[i] != 0) begin
                    ticks[i]++;
                    ex[i] = (ticks[i] % per[i]) == 0;
                end
            end
            if (overrun_clr) for (int i = 0; i < 4; i++) ovr[i] = 0;
            for (int i = 0; i < 4; i++) begin
                if (ex[i]) begin
                    if (pend[i] && !(m_hs && m_id == i)) ovr[i] = 1;
                    newp[i] = 1;
                end
            end
            if (!m_valid) begin
                for (int j = 1; j <= 4; j++) begin
                    if (!m_valid && pend[(m_last + j) % 4]) begin
                        m_valid = 1;
                        m_id    = (m_last + j) % 4;
                        exp_q.push_back(m_id);
                    end
                end
            end else if (evt_ready) begin
                m_valid = 0;
                m_last  = m_id;
            end
            for (int i = 0; i < 4; i++) pend[i] = newp[i];
        end
    end

    // Monitor: each new presentation must match the next expected grant.
    bit mon_prev = 0;
    int mon_exp;
    always @(negedge clk) begin
        if (rst_n && evt_valid && !mon_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", int'(evt_id), -1);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("grant_id", int'(evt_id), mon_exp);
            end
        end
        mon_prev = rst_n && evt_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] p);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (!base_tick && n < 40) begin step(); n++; end
        if (!base_tick) chk({name, "_tick_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!evt_valid && n < 60) begin step(); n++; end
        if (!evt_valid) chk({name, "_valid_timeout"}, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; pause = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0;
        cfg_period = 8'd0; evt_ready = 1'b0; overrun_clr = 1'b0;
        steps(3);
        rst_n = 1'b1;

        // Steady single channel.
        evt_ready = 1'b1;
        cfg(2'd0, 8'd3);
        steps(40);

        // Round robin between ch0 and ch2.
        cfg(2'd0, 8'd1);
        cfg(2'd2, 8'd1);
        steps(30);

        // Overrun on ch1 with a stalled consumer.
        cfg(2'd0, 8'd0);
        cfg(2'd2, 8'd0);
        steps(6);
        evt_ready = 1'b0;
        cfg(2'd1, 8'd1);
        steps(16);
        chk("s3_overrun", int'(overrun), 2);
        chk("s3_valid", int'(evt_valid), 1);
        chk("s3_id", int'(evt_id), 1);
        wait_tick("s3");
        step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("s3_overrun_clr", int'(overrun), 0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        steps(10);
        evt_ready = 1'b1;
        cfg(2'd1, 8'd0);
        steps(6);

        // Pause for 20 cycles one cycle after the first base tick.
        cfg(2'd3, 8'd2);
        wait_tick("s4");
        step();
        pause = 1'b1;
        steps(20);
        pause = 1'b0;
        steps(20);
        cfg(2'd3, 8'd0);
        steps(6);

        // Config write to a presented channel and to an expiring channel.
        evt_ready = 1'b0;
        cfg(2'd0, 8'd1);
        wait_valid("s5");
        cfg(2'd0, 8'd2);
        chk("s5_valid_held", int'(evt_valid), 1);
        chk("s5_id_held", int'(evt_id), 0);
        evt_ready = 1'b1;
        cfg(2'd0, 8'd0);
        cfg(2'd2, 8'd1);
        wait_tick("s5b");
        cfg(2'd2, 8'd1);
        steps(2);
        cfg(2'd2, 8'd0);
        steps(8);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            cfg_we      = ($urandom_range(0, 19) == 0);
            cfg_ch      = 2'($urandom_range(0, 3));
            cfg_period  = 8'($urandom_range(0, 4));
            evt_ready   = ($urandom_range(0, 9) < 6);
            pause       = ($urandom_range(0, 9) == 0);
            overrun_clr = ($urandom_range(0, 19) == 0);
            step();
        end
        cfg_we = 1'b0; pause = 1'b0; overrun_clr = 1'b0;

        // Reset while an event is presented.
        evt_ready = 1'b0;
        cfg(2'd3, 8'd1);
        wait_valid("s6");
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_valid", int'(evt_valid), 0);
        chk("s6_async_id", int'(evt_id), 0);
        chk("s6_async_overrun", int'(overrun), 0);
        chk("s6_async_tick", int'(base_tick), 0);
        steps(2);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        steps(50);
        chk("s6_no_event", int'(evt_valid), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
